branch_issue_unit: RTL
======================

# branch_issue_unit

Parametrised branch execution block for the Tomasulo core: an RS_DEPTH-entry branch reservation station, CDB operand wakeup, lowest-index-ready issue select, and a registered result stage with a valid/ready handshake toward the CDB arbiter. It sits between dispatch and the CDB. Its resolved direction and target are compared against the fetch-time prediction, and it reports a mispredict per branch so the ROB can redirect fetch at commit.

## Interface
- RS_DEPTH, 4, number of reservation-station entries (power of two, ≥2)
- TAG_W, 4, ROB tag width
- XLEN, 32, data/address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state except flush
- flush  in  1  synchronous clear of all entries and the output register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists this cycle
- disp_op  in  OP_W  branch opcode (branch_pkg)
- disp_vj, disp_vk  in  XLEN  operand values
- disp_qj_busy, disp_qk_busy  in  1  1 = operand still pending on tag
- disp_qj, disp_qk  in  TAG_W  producing ROB tags
- disp_imm, disp_pc  in  XLEN  sign-extended immediate, instruction PC
- disp_pred_taken  in  1  fetch prediction
- disp_dest  in  TAG_W  destination ROB tag
- cdb_valid, cdb_tag, cdb_data  in  1/TAG_W/XLEN  broadcast from other units
- out_valid  out  1  result held
- out_ready  in  1  arbiter accepts result
- out_tag  out  TAG_W;  out_taken  out  1;  out_target  out  XLEN  actual next PC
- out_link  out  XLEN  PC+4 for JAL/JALR, else 0
- out_mispredict  out  1  actual next PC differs from predicted path

## Operation
- Entry fields: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, imm, pc, pred, dest.
- Allocation: when disp_valid && disp_ready, write the lowest-index free entry. A slot freed by issue in the same cycle is not reusable until the next cycle.
- Wakeup: each busy entry whose qX_busy is set and whose qX == cdb_tag on cdb_valid captures cdb_data and clears qX_busy. Dispatch bypass: if a dispatched operand's tag matches the CDB in the same cycle, that operand is written already ready.
- Ready: busy && !qj_busy && !qk_busy. Select the lowest-index ready entry.
- Issue condition: a ready entry exists && (!out_valid || out_ready). On issue the entry is freed and the output register is loaded. If no entry issues and out_valid && out_ready, out_valid clears.
- Compute (branch_alu):
  - BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU (unsigned): taken = compare result; target = taken ? pc+imm : pc+4; mispredict = taken ^ pred.
  - JAL: taken=1; target=pc+imm; link=pc+4; mispredict = !pred.
  - JALR: taken=1; target=(vj+imm)&~1; link=pc+4; mispredict=1 (no target prediction).
- Unknown opcode: the entry is freed on issue and no output is produced (the output register is not loaded).
- All adds are modulo 2^XLEN and wrap silently.
- Flush: at the next edge, all busy bits and out_valid clear. Dispatch and issue in the flush cycle are discarded. Flush acts even when rdy=0.
- rdy=0: no allocation, wakeup, issue or output change. disp_ready is forced to 0.

## Timing
- Reset (async, rst_n low): all entries not busy, out_valid=0, out_tag/out_taken/out_target/out_link/out_mispredict=0. disp_ready=1 once rdy=1.
- Latency:
  - Dispatch with both operands ready → out_valid one edge after the entry's first ready cycle, i.e. 2 edges after dispatch.
  - CDB wakeup → issue eligibility on the following cycle.
- Throughput: one result per cycle while out_ready is held high.
- Handshake: out_* is stable while out_valid && !out_ready.
- Full: disp_ready=0 when all RS_DEPTH entries are busy. A request asserted while disp_ready=0 is ignored, not queued.
- Simultaneous events:
  - Flush beats dispatch, issue and wakeup.
  - A CDB match on an entry issuing this cycle is irrelevant, since only ready entries issue.

## Structure
- Shared package branch_pkg: OP_W and the BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR encodings shared with the decoder, and PC_STEP=4.
- Sub-module branch_alu: purely combinational op/vj/vk/imm/pc/pred → taken/target/link/mispredict. It is reused by the issue stage.

## Test plan
- Reset, then dispatch BEQ, vj=vk=5, pc=0x100, imm=0x20, pred=0 → 2 edges later out_valid, taken=1, target=0x120, mispredict=1.
- Dispatch BLT with qj_busy, qj=3 and vk=0; CDB tag 3 data=0xFFFFFFFF one cycle later → issue the next cycle with taken=1. The same with BLTU → taken=0, target=pc+4.
- Fill all 4 entries with pending operands → disp_ready=0 and a fifth request is ignored. One wakeup → one issue, and disp_ready=1 the cycle after.
- Hold out_ready=0 with 2 ready entries → out_* stays stable and entries are retained. Release → two results on consecutive cycles, lower index first.
- JALR vj=0x1003, imm=4, pc=0x40 → target=0x1006, link=0x44, mispredict=1. JAL pred=1 → mispredict=0.
- Flush with 3 busy entries and out_valid=1 → next cycle all empty, out_valid=0. A dispatch in the flush cycle is lost. Asserting rst_n low mid-operation clears everything asynchronously.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch definitions: opcode encodings (common with the decoder),
// opcode width and the sequential PC step.
package branch_pkg;

  localparam int OP_W    = 4;
  localparam int PC_STEP = 4;

  // Branch opcodes as produced by the decoder; unlisted codes are illegal
  typedef enum logic [OP_W-1:0] {
    OP_BEQ  = 4'h0,
    OP_BNE  = 4'h1,
    OP_BLT  = 4'h4,
    OP_BGE  = 4'h5,
    OP_BLTU = 4'h6,
    OP_BGEU = 4'h7,
    OP_JAL  = 4'h8,
    OP_JALR = 4'h9
  } branch_op_e;

  // True for the six compare-and-branch opcodes
  function automatic logic isCondBranch(input logic [OP_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: isCondBranch = 1'b1;
      default:                                          isCondBranch = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_issue_unit_if.sv
// Dispatch, CDB and result-handshake bundle of the branch issue unit.
// The unit connects through the slave modport; the surrounding core
// (dispatch, CDB, arbiter) drives it through the master modport.
interface branch_issue_unit_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  import branch_pkg::*;

  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj;
  logic [XLEN-1:0]  disp_vk;
  logic             disp_qj_busy;
  logic             disp_qk_busy;
  logic [TAG_W-1:0] disp_qj;
  logic [TAG_W-1:0] disp_qk;
  logic [XLEN-1:0]  disp_imm;
  logic [XLEN-1:0]  disp_pc;
  logic             disp_pred_taken;
  logic [TAG_W-1:0] disp_dest;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_link;
  logic             out_mispredict;

  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_imm, disp_pc, disp_pred_taken, disp_dest,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output out_valid, out_tag, out_taken, out_target, out_link, out_mispredict,
    input  out_ready
  );

  modport master (
    output disp_valid, disp_op, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_imm, disp_pc, disp_pred_taken, disp_dest,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  out_valid, out_tag, out_taken, out_target, out_link, out_mispredict,
    output out_ready
  );

endinterface

// File: rtl/branch_alu.sv
// Combinational branch resolver: direction, actual next PC, link value and
// mispredict flag for one branch. valid_o is low for illegal opcodes.
module branch_alu
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] vj_i,
  input  logic [XLEN-1:0] vk_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_i,
  output logic            valid_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            mispredict_o
);

  logic [XLEN-1:0] seqPc;
  logic [XLEN-1:0] branchPc;
  logic [XLEN-1:0] jalrSum;

  assign seqPc    = pc_i + XLEN'(PC_STEP);
  assign branchPc = pc_i + imm_i;
  assign jalrSum  = vj_i + imm_i;

  // Decode the opcode and produce the resolved path; JALR always counts as
  // mispredicted because fetch never predicts an indirect target
  always_comb begin
    valid_o      = 1'b1;
    taken_o      = 1'b0;
    target_o     = seqPc;
    link_o       = '0;
    mispredict_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = (vj_i == vk_i);
      OP_BNE:  taken_o = (vj_i != vk_i);
      OP_BLT:  taken_o = ($signed(vj_i) <  $signed(vk_i));
      OP_BGE:  taken_o = ($signed(vj_i) >= $signed(vk_i));
      OP_BLTU: taken_o = (vj_i <  vk_i);
      OP_BGEU: taken_o = (vj_i >= vk_i);
      OP_JAL: begin
        taken_o  = 1'b1;
        target_o = branchPc;
        link_o   = seqPc;
      end
      OP_JALR: begin
        taken_o  = 1'b1;
        target_o = jalrSum & {{(XLEN-1){1'b1}}, 1'b0};
        link_o   = seqPc;
      end
      default: valid_o = 1'b0;
    endcase
    if (isCondBranch(op_i)) begin
      if (taken_o) begin
        target_o = branchPc;
      end
      mispredict_o = taken_o ^ pred_i;
    end else if (op_i == OP_JAL) begin
      mispredict_o = ~pred_i;
    end else if (op_i == OP_JALR) begin
      mispredict_o = 1'b1;
    end
  end

endmodule

// File: rtl/branch_issue_unit.sv
// Branch reservation station with CDB wakeup, lowest-index-ready issue and a
// registered result stage handshaking with the CDB arbiter.
module branch_issue_unit
  import branch_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4,
  parameter int XLEN     = 32
) (
  input logic           clk,
  input logic           rst_n,
  input logic           rdy,
  input logic           flush,
  branch_issue_unit_if.slave bus
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0] busy_q;
  logic [RS_DEPTH-1:0] qjBusy_q;
  logic [RS_DEPTH-1:0] qkBusy_q;
  logic [RS_DEPTH-1:0] pred_q;
  logic [OP_W-1:0]     op_q   [RS_DEPTH];
  logic [XLEN-1:0]     vj_q   [RS_DEPTH];
  logic [XLEN-1:0]     vk_q   [RS_DEPTH];
  logic [XLEN-1:0]     imm_q  [RS_DEPTH];
  logic [XLEN-1:0]     pc_q   [RS_DEPTH];
  logic [TAG_W-1:0]    qj_q   [RS_DEPTH];
  logic [TAG_W-1:0]    qk_q   [RS_DEPTH];
  logic [TAG_W-1:0]    dest_q [RS_DEPTH];

  logic             outValid_q;
  logic [TAG_W-1:0] outTag_q;
  logic             outTaken_q;
  logic [XLEN-1:0]  outTarget_q;
  logic [XLEN-1:0]  outLink_q;
  logic             outMisp_q;

  logic [RS_DEPTH-1:0] readyVec;
  logic                anyFree;
  logic                anyReady;
  logic [IDX_W-1:0]    allocIdx;
  logic [IDX_W-1:0]    issueIdx;
  logic                dispFire;
  logic                issueFire;

  logic            dispQjBusy_d;
  logic            dispQkBusy_d;
  logic [XLEN-1:0] dispVj_d;
  logic [XLEN-1:0] dispVk_d;

  logic            aluValid;
  logic            aluTaken;
  logic [XLEN-1:0] aluTarget;
  logic [XLEN-1:0] aluLink;
  logic            aluMisp;

  assign readyVec = busy_q & ~qjBusy_q & ~qkBusy_q;

  // Priority-encode the lowest free slot for dispatch and the lowest ready
  // slot for issue; scanning downwards lets the lowest index win
  always_comb begin
    anyFree  = 1'b0;
    anyReady = 1'b0;
    allocIdx = '0;
    issueIdx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        anyFree  = 1'b1;
        allocIdx = IDX_W'(i);
      end
      if (readyVec[i]) begin
        anyReady = 1'b1;
        issueIdx = IDX_W'(i);
      end
    end
  end

  assign bus.disp_ready = rdy & anyFree;
  assign dispFire       = bus.disp_valid & bus.disp_ready;
  assign issueFire      = rdy & anyReady & (~outValid_q | bus.out_ready);

  // Dispatch bypass: an operand whose producer is on the CDB right now is
  // written as already available
  always_comb begin
    dispQjBusy_d = bus.disp_qj_busy;
    dispQkBusy_d = bus.disp_qk_busy;
    dispVj_d     = bus.disp_vj;
    dispVk_d     = bus.disp_vk;
    if (bus.disp_qj_busy && bus.cdb_valid && (bus.cdb_tag == bus.disp_qj)) begin
      dispQjBusy_d = 1'b0;
      dispVj_d     = bus.cdb_data;
    end
    if (bus.disp_qk_busy && bus.cdb_valid && (bus.cdb_tag == bus.disp_qk)) begin
      dispQkBusy_d = 1'b0;
      dispVk_d     = bus.cdb_data;
    end
  end

  branch_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op_i         (op_q[issueIdx]),
    .vj_i         (vj_q[issueIdx]),
    .vk_i         (vk_q[issueIdx]),
    .imm_i        (imm_q[issueIdx]),
    .pc_i         (pc_q[issueIdx]),
    .pred_i       (pred_q[issueIdx]),
    .valid_o      (aluValid),
    .taken_o      (aluTaken),
    .target_o     (aluTarget),
    .link_o       (aluLink),
    .mispredict_o (aluMisp)
  );

  // Station entries: flush empties everything, otherwise wakeup, issue-free
  // and allocation; allocation only targets slots already free this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      qjBusy_q <= '0;
      qkBusy_q <= '0;
      pred_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && qjBusy_q[i] && bus.cdb_valid && (qj_q[i] == bus.cdb_tag)) begin
          vj_q[i]     <= bus.cdb_data;
          qjBusy_q[i] <= 1'b0;
        end
        if (busy_q[i] && qkBusy_q[i] && bus.cdb_valid && (qk_q[i] == bus.cdb_tag)) begin
          vk_q[i]     <= bus.cdb_data;
          qkBusy_q[i] <= 1'b0;
        end
      end
      if (issueFire) begin
        busy_q[issueIdx] <= 1'b0;
      end
      if (dispFire) begin
        busy_q[allocIdx]   <= 1'b1;
        op_q[allocIdx]     <= bus.disp_op;
        vj_q[allocIdx]     <= dispVj_d;
        vk_q[allocIdx]     <= dispVk_d;
        qjBusy_q[allocIdx] <= dispQjBusy_d;
        qkBusy_q[allocIdx] <= dispQkBusy_d;
        qj_q[allocIdx]     <= bus.disp_qj;
        qk_q[allocIdx]     <= bus.disp_qk;
        imm_q[allocIdx]    <= bus.disp_imm;
        pc_q[allocIdx]     <= bus.disp_pc;
        pred_q[allocIdx]   <= bus.disp_pred_taken;
        dest_q[allocIdx]   <= bus.disp_dest;
      end
    end
  end

  // Result register: loads on a legal issue, drops a consumed result when
  // nothing replaces it; an illegal opcode issues without producing output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outTag_q    <= '0;
      outTaken_q  <= 1'b0;
      outTarget_q <= '0;
      outLink_q   <= '0;
      outMisp_q   <= 1'b0;
    end else if (flush) begin
      outValid_q <= 1'b0;
    end else if (rdy) begin
      if (issueFire && aluValid) begin
        outValid_q  <= 1'b1;
        outTag_q    <= dest_q[issueIdx];
        outTaken_q  <= aluTaken;
        outTarget_q <= aluTarget;
        outLink_q   <= aluLink;
        outMisp_q   <= aluMisp;
      end else if (bus.out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = outValid_q;
  assign bus.out_tag        = outTag_q;
  assign bus.out_taken      = outTaken_q;
  assign bus.out_target     = outTarget_q;
  assign bus.out_link       = outLink_q;
  assign bus.out_mispredict = outMisp_q;

endmodule
